trap_sequencer: RTL and testbench

//  Sequences all M-mode trap entry and MRET exit around the CSR/exception unit.

---
 rtl/trap_sequencer.sv | 170 +++++++++++++++++
 tb/tb_trap_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// M-mode trap entry / MRET exit sequencer.
// Arbitrates traps, drains the pipe, strobes the CSR commit and redirects fetch.
module trap_sequencer #(
  parameter int XLEN          = 32,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [5:0]      exc_vec,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_addr,
  input  logic [2:0]      irq_lines,
  input  logic [XLEN-1:0] csr_mie,
  input  logic            csr_mstatus_mie,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic [XLEN-1:0] next_pc,
  input  logic            mret_req,
  input  logic            pipe_idle,
  output logic            busy,
  output logic            flush,
  output logic            trap_commit,
  output logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_tval,
  output logic            mret_commit,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            drain_timeout
);

  localparam int CW = $clog2(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_COMMIT,
    S_REDIRECT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            mret_q, mret_d;
  logic            tmo_q, tmo_d;

  // enabled interrupts ordered {mei, msi, mti}
  logic [2:0] irq_en;
  assign irq_en = {irq_lines[2] & csr_mie[11],
                   irq_lines[0] & csr_mie[3],
                   irq_lines[1] & csr_mie[7]}
                & {3{csr_mstatus_mie}};

  logic unused_mie;
  assign unused_mie = ^{csr_mie[XLEN-1:12], csr_mie[10:8],
                        csr_mie[6:4], csr_mie[2:0]};

  // state and latched trap context
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
      mret_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
      mret_q  <= mret_d;
      tmo_q   <= tmo_d;
    end
  end

  // arbitration and sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    mret_d  = mret_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (|exc_vec) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          mret_d  = 1'b0;
          epc_d   = exc_pc;
          tval_d  = '0;
          if (exc_vec[0]) begin
            cause_d = XLEN'(0);
            tval_d  = exc_pc;
          end else if (exc_vec[1]) begin
            cause_d = XLEN'(2);
          end else if (exc_vec[2]) begin
            cause_d = XLEN'(3);
          end else if (exc_vec[3]) begin
            cause_d = XLEN'(11);
          end else if (exc_vec[4]) begin
            cause_d = XLEN'(4);
            tval_d  = exc_addr;
          end else begin
            cause_d = XLEN'(6);
            tval_d  = exc_addr;
          end
        end else if (|irq_en) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          mret_d  = 1'b0;
          epc_d   = next_pc;
          tval_d  = '0;
          if (irq_en[2])
            cause_d = {1'b1, (XLEN-1)'(11)};
          else if (irq_en[1])
            cause_d = {1'b1, (XLEN-1)'(3)};
          else
            cause_d = {1'b1, (XLEN-1)'(7)};
        end else if (mret_req) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          mret_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (pipe_idle || cnt_q == CNT_MAX) begin
          state_d = mret_q ? S_REDIRECT : S_COMMIT;
          if (!pipe_idle) tmo_d = 1'b1;
        end
      end
      S_COMMIT:   state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // fetch redirect target
  always_comb begin
    redirect_pc = '0;
    if (state_q == S_REDIRECT) begin
      if (mret_q)
        redirect_pc = csr_mepc;
      else if (csr_mtvec[1:0] == 2'b01 && cause_q[XLEN-1])
        redirect_pc = {csr_mtvec[XLEN-1:2], 2'b00}
                    + {cause_q[XLEN-3:0], 2'b00};
      else
        redirect_pc = {csr_mtvec[XLEN-1:2], 2'b00};
    end
  end

  assign busy           = state_q != S_IDLE;
  assign flush          = state_q == S_DRAIN;
  assign trap_commit    = state_q == S_COMMIT;
  assign redirect_valid = state_q == S_REDIRECT;
  assign mret_commit    = redirect_valid & mret_q;
  assign trap_cause     = cause_q;
  assign trap_epc       = epc_q;
  assign trap_tval      = tval_q;
  assign drain_timeout  = tmo_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer.
// One task per scenario, expected values hand-computed.
module tb_trap_sequencer;

  localparam int XLEN = 32;
  localparam int TMO  = 16;

  logic            clk = 1'b0;
  logic            nrst;
  logic [5:0]      exc_vec;
  logic [XLEN-1:0] exc_pc, exc_addr;
  logic [2:0]      irq_lines;
  logic [XLEN-1:0] csr_mie;
  logic            csr_mstatus_mie;
  logic [XLEN-1:0] csr_mtvec, csr_mepc, next_pc;
  logic            mret_req, pipe_idle;
  logic            busy, flush, trap_commit;
  logic [XLEN-1:0] trap_cause, trap_epc, trap_tval;
  logic            mret_commit, redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            drain_timeout;

  int pass = 0;
  int total = 0;

  trap_sequencer #(.XLEN(XLEN), .DRAIN_TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst),
    .exc_vec(exc_vec), .exc_pc(exc_pc), .exc_addr(exc_addr),
    .irq_lines(irq_lines), .csr_mie(csr_mie),
    .csr_mstatus_mie(csr_mstatus_mie), .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc), .next_pc(next_pc),
    .mret_req(mret_req), .pipe_idle(pipe_idle),
    .busy(busy), .flush(flush), .trap_commit(trap_commit),
    .trap_cause(trap_cause), .trap_epc(trap_epc),
    .trap_tval(trap_tval), .mret_commit(mret_commit),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    exc_vec = '0; exc_pc = '0; exc_addr = '0;
    irq_lines = '0; csr_mie = '0; csr_mstatus_mie = 1'b0;
    csr_mtvec = 32'h8000_0001; csr_mepc = '0; next_pc = '0;
    mret_req = 1'b0; pipe_idle = 1'b1;
    tick(); tick();
    total++;
    if ({busy, flush, trap_commit, mret_commit, redirect_valid,
         drain_timeout} !== 6'b0 || trap_cause !== '0
        || trap_epc !== '0 || trap_tval !== '0
        || redirect_pc !== '0)
      $display("FAIL reset_outputs got busy=%b cause=%h pc=%h want all 0",
               busy, trap_cause, redirect_pc);
    else pass++;
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_ecall();
    exc_pc = 32'h100; exc_vec = 6'b001000;
    tick();
    exc_vec = '0;
    total++;
    if ({busy, flush, trap_commit} !== 3'b110)
      $display("FAIL ecall_drain got %b want 110",
               {busy, flush, trap_commit});
    else pass++;
    tick();
    total++;
    if (trap_commit !== 1'b1 || trap_cause !== 32'd11
        || trap_tval !== 32'd0 || trap_epc !== 32'h100
        || redirect_valid !== 1'b0)
      $display("FAIL ecall_commit got c=%b cause=%h tval=%h epc=%h want 1 b 0 100",
               trap_commit, trap_cause, trap_tval, trap_epc);
    else pass++;
    tick();
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0000
        || trap_commit !== 1'b0 || mret_commit !== 1'b0)
      $display("FAIL ecall_redirect got v=%b pc=%h want 1 80000000",
               redirect_valid, redirect_pc);
    else pass++;
    tick();
    total++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0)
      $display("FAIL ecall_idle got busy=%b want 0", busy);
    else pass++;
  endtask

  task automatic test_irq();
    csr_mie = 32'h888; irq_lines = 3'b111; next_pc = 32'h200;
    csr_mstatus_mie = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0)
      $display("FAIL irq_masked got busy=%b want 0", busy);
    else pass++;
    csr_mstatus_mie = 1'b1;
    tick();
    irq_lines = '0;
    tick();
    total++;
    if (trap_commit !== 1'b1 || trap_cause !== 32'h8000_000B
        || trap_epc !== 32'h200 || trap_tval !== 32'd0)
      $display("FAIL irq_commit got c=%b cause=%h epc=%h tval=%h want 1 8000000b 200 0",
               trap_commit, trap_cause, trap_epc, trap_tval);
    else pass++;
    tick();
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_002C)
      $display("FAIL irq_redirect got v=%b pc=%h want 1 8000002c",
               redirect_valid, redirect_pc);
    else pass++;
    tick();
    irq_lines = 3'b010;
    tick();
    irq_lines = '0;
    tick();
    total++;
    if (trap_commit !== 1'b1 || trap_cause !== 32'h8000_0007)
      $display("FAIL mti_commit got c=%b cause=%h want 1 80000007",
               trap_commit, trap_cause);
    else pass++;
    csr_mtvec = 32'h8000_0003;
    tick();
    total++;
    if (redirect_pc !== 32'h8000_0000)
      $display("FAIL mti_mode3 got pc=%h want 80000000", redirect_pc);
    else pass++;
    csr_mtvec = 32'h8000_0001;
    csr_mstatus_mie = 1'b0;
    tick();
  endtask

  task automatic test_exc_priority();
    exc_pc = 32'h300; exc_addr = 32'h1003; exc_vec = 6'b010010;
    tick();
    exc_vec = 6'b010000;
    tick();
    exc_vec = '0;
    total++;
    if (trap_commit !== 1'b1 || trap_cause !== 32'd2
        || trap_tval !== 32'd0 || trap_epc !== 32'h300)
      $display("FAIL illegal_commit got c=%b cause=%h tval=%h want 1 2 0",
               trap_commit, trap_cause, trap_tval);
    else pass++;
    tick(); tick();
    total++;
    if (busy !== 1'b0)
      $display("FAIL busy_drop got busy=%b want 0", busy);
    else pass++;
    exc_vec = 6'b010000;
    tick();
    exc_vec = '0;
    tick();
    total++;
    if (trap_cause !== 32'd4 || trap_tval !== 32'h1003)
      $display("FAIL ldmis_commit got cause=%h tval=%h want 4 1003",
               trap_cause, trap_tval);
    else pass++;
    tick(); tick();
    exc_vec = 6'b001001;
    tick();
    exc_vec = '0;
    tick();
    total++;
    if (trap_cause !== 32'd0 || trap_tval !== 32'h300)
      $display("FAIL ifmis_commit got cause=%h tval=%h want 0 300",
               trap_cause, trap_tval);
    else pass++;
    tick(); tick();
  endtask

  task automatic test_mret();
    csr_mepc = 32'h444; mret_req = 1'b1;
    tick();
    mret_req = 1'b0;
    total++;
    if (busy !== 1'b1 || flush !== 1'b1)
      $display("FAIL mret_drain got busy=%b flush=%b want 1 1",
               busy, flush);
    else pass++;
    tick();
    total++;
    if (trap_commit !== 1'b0 || mret_commit !== 1'b1
        || redirect_valid !== 1'b1 || redirect_pc !== 32'h444)
      $display("FAIL mret_redirect got c=%b m=%b v=%b pc=%h want 0 1 1 444",
               trap_commit, mret_commit, redirect_valid, redirect_pc);
    else pass++;
    tick();
    total++;
    if (busy !== 1'b0 || mret_commit !== 1'b0)
      $display("FAIL mret_idle got busy=%b m=%b want 0 0",
               busy, mret_commit);
    else pass++;
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    pipe_idle = 1'b0; exc_pc = 32'h500; exc_vec = 6'b000100;
    tick();
    exc_vec = '0;
    for (int i = 1; i <= TMO + 4; i++) begin
      tick();
      if (trap_commit === 1'b1) begin
        n = i;
        break;
      end
    end
    total++;
    if (n !== TMO)
      $display("FAIL timeout_latency got %0d want %0d", n, TMO);
    else pass++;
    total++;
    if (drain_timeout !== 1'b1 || trap_cause !== 32'd3)
      $display("FAIL timeout_flag got tmo=%b cause=%h want 1 3",
               drain_timeout, trap_cause);
    else pass++;
    pipe_idle = 1'b1;
    tick(); tick();
    exc_vec = 6'b001000;
    tick();
    exc_vec = '0;
    tick(); tick(); tick();
    total++;
    if (drain_timeout !== 1'b1 || busy !== 1'b0)
      $display("FAIL timeout_sticky got tmo=%b busy=%b want 1 0",
               drain_timeout, busy);
    else pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    pipe_idle = 1'b0; exc_vec = 6'b001000; exc_pc = 32'h600;
    tick();
    exc_vec = '0;
    tick();
    nrst = 1'b0;
    #2;
    total++;
    if ({busy, flush, trap_commit, mret_commit, redirect_valid,
         drain_timeout} !== 6'b0 || trap_cause !== '0
        || trap_epc !== '0 || redirect_pc !== '0)
      $display("FAIL midreset_outputs got busy=%b tmo=%b cause=%h want 0",
               busy, drain_timeout, trap_cause);
    else pass++;
    tick();
    nrst = 1'b1;
    pipe_idle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (trap_commit !== 1'b0 || redirect_valid !== 1'b0
          || busy !== 1'b0) bad++;
    end
    total++;
    if (bad !== 0)
      $display("FAIL midreset_quiet got %0d strobes want 0", bad);
    else pass++;
    exc_pc = 32'h700; exc_vec = 6'b001000;
    tick();
    exc_vec = '0;
    tick();
    total++;
    if (trap_commit !== 1'b1 || trap_epc !== 32'h700
        || trap_cause !== 32'd11)
      $display("FAIL midreset_next got c=%b epc=%h want 1 700",
               trap_commit, trap_epc);
    else pass++;
    tick();
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0000)
      $display("FAIL midreset_redirect got v=%b pc=%h want 1 80000000",
               redirect_valid, redirect_pc);
    else pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_irq();
    test_exc_priority();
    test_mret();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
